// File: rtl/fifo_nibble_writer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// fifo_nibble_writer
//
// Accepts bytes over a valid/ready handshake and writes each one as two 4-bit nibbles into the
// write side of a 4-bit asynchronous FIFO. A byte is captured into a holding register on
// transfer and then written out over two write-enabled cycles. Back-to-back bytes stream at one
// byte per two cycles because a new byte may be accepted on the same edge that writes the
// second nibble of the current one. Any cycle with fifo_full high stalls the writer in place.
//
// Parameters
//   LSB_FIRST    1: byte[3:0] written first; 0: byte[7:4] written first
//   CNT_W        width of byte_count and stall_count
//
// Ports
//   wr_clk       write-domain clock, rising edge
//   wr_rst       asynchronous active-low reset
//   s_valid      upstream byte valid
//   s_data       upstream byte
//   s_ready      block can accept s_data this cycle
//   fifo_full    full flag from the FIFO write side
//   fifo_wr_en   FIFO write strobe (never high while fifo_full is high)
//   fifo_data    nibble presented to the FIFO
//   busy         a byte is held and not yet fully written
//   byte_count   bytes fully written, wraps modulo 2^CNT_W
//   stall_count  busy cycles lost to fifo_full, saturates at all-ones
// ---------------------------------------------------------------------------------------------
module fifo_nibble_writer #(
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [3:0]       fifo_data,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StSendFirst  = 2'd1,
        StSendSecond = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             transfer;
    logic             second_written;
    logic [3:0]       first_nib;
    logic [3:0]       second_nib;

    // Nibble order is fixed at elaboration time.
    assign first_nib  = LSB_FIRST ? byte_q[3:0] : byte_q[7:4];
    assign second_nib = LSB_FIRST ? byte_q[7:4] : byte_q[3:0];

    // -----------------------------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        s_ready    = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_data  = 4'h0;
        busy       = 1'b0;

        case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    state_d = StSendFirst;
                end
            end

            StSendFirst: begin
                busy       = 1'b1;
                fifo_wr_en = !fifo_full;
                fifo_data  = first_nib;
                if (!fifo_full) begin
                    state_d = StSendSecond;
                end
            end

            StSendSecond: begin
                busy       = 1'b1;
                fifo_wr_en = !fifo_full;
                fifo_data  = second_nib;
                // The holding register frees up on the same edge the last nibble leaves, so a new
                // byte can be accepted here without a bubble cycle.
                s_ready    = !fifo_full;
                if (!fifo_full) begin
                    state_d = s_valid ? StSendFirst : StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign transfer       = s_valid && s_ready;
    assign second_written = (state_q == StSendSecond) && fifo_wr_en;

    // -----------------------------------------------------------------------------------------
    // Holding register and counters
    // -----------------------------------------------------------------------------------------
    always_comb begin
        byte_d = byte_q;
        if (transfer) begin
            byte_d = s_data;
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (second_written) begin
            byte_cnt_d = byte_cnt_q + CntOne;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (busy && fifo_full && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q     <= StIdle;
            byte_q      <= 8'h00;
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign byte_count  = byte_cnt_q;
    assign stall_count = stall_cnt_q;

    // -----------------------------------------------------------------------------------------
    // Simulation-time invariants
    // -----------------------------------------------------------------------------------------
    // A write into a full FIFO would lose a nibble.
    a_no_write_when_full : assert property (
        @(posedge wr_clk) disable iff (!wr_rst) fifo_wr_en |-> !fifo_full
    );

    // A stalled nibble must be presented unchanged on the following cycle.
    a_stall_holds_data : assert property (
        @(posedge wr_clk) disable iff (!wr_rst)
        (busy && fifo_full) |=> ($stable(byte_q) && $stable(fifo_data) && busy)
    );

endmodule

// File: tb/tb_fifo_nibble_writer.sv
`timescale 1ns / 1ps
// Bench for fifo_nibble_writer: three instances (default, MSB-first, 2-bit counters) share one
// stimulus stream. A per-cycle vector table drives and checks the main instance; nibble queues
// filled at drive time are drained by write monitors on every instance.
module tb_fifo_nibble_writer;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       fifo_full;

    logic       ready, wr_en, busy;
    logic [3:0] data;
    logic [7:0] bcnt, scnt;

    logic       m_ready, m_wr_en, m_busy;
    logic [3:0] m_data;
    logic [7:0] m_bcnt, m_scnt;

    logic       n_ready, n_wr_en, n_busy;
    logic [3:0] n_data;
    logic [1:0] n_bcnt, n_scnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] q_main[$];
    logic [3:0] q_msb[$];
    logic [3:0] q_small[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       full;
        logic       xfer;
        logic       e_ready;
        logic       e_wr;
        logic [3:0] e_data;
        logic       e_busy;
        int         e_bcnt;
        int         e_scnt;
    } vec_t;

    vec_t vecs[$];

    always #5 wr_clk = ~wr_clk;

    fifo_nibble_writer u_dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .s_valid(s_valid), .s_data(s_data), .s_ready(ready),
        .fifo_full(fifo_full), .fifo_wr_en(wr_en), .fifo_data(data), .busy(busy),
        .byte_count(bcnt), .stall_count(scnt)
    );

    fifo_nibble_writer #(.LSB_FIRST(1'b0), .CNT_W(8)) u_msb (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .s_valid(s_valid), .s_data(s_data), .s_ready(m_ready),
        .fifo_full(fifo_full), .fifo_wr_en(m_wr_en), .fifo_data(m_data), .busy(m_busy),
        .byte_count(m_bcnt), .stall_count(m_scnt)
    );

    fifo_nibble_writer #(.LSB_FIRST(1'b1), .CNT_W(2)) u_small (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .s_valid(s_valid), .s_data(s_data), .s_ready(n_ready),
        .fifo_full(fifo_full), .fifo_wr_en(n_wr_en), .fifo_data(n_data), .busy(n_busy),
        .byte_count(n_bcnt), .stall_count(n_scnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add_vec(input logic v, input logic [7:0] d, input logic full, input logic xfer,
                           input logic e_ready, input logic e_wr, input logic [3:0] e_data,
                           input logic e_busy, input int e_bcnt, input int e_scnt);
        vec_t r;
        r.v = v; r.d = d; r.full = full; r.xfer = xfer;
        r.e_ready = e_ready; r.e_wr = e_wr; r.e_data = e_data; r.e_busy = e_busy;
        r.e_bcnt = e_bcnt; r.e_scnt = e_scnt;
        vecs.push_back(r);
    endtask

    // Queue expected nibbles for a byte the bench expects to be accepted.
    task automatic push_byte(input logic [7:0] b);
        q_main.push_back(b[3:0]);  q_main.push_back(b[7:4]);
        q_small.push_back(b[3:0]); q_small.push_back(b[7:4]);
        q_msb.push_back(b[7:4]);   q_msb.push_back(b[3:0]);
    endtask

    // Write monitors: a strobe seen at the falling edge is committed at the next rising edge.
    always @(negedge wr_clk) begin
        if (wr_rst === 1'b1) begin
            if (wr_en) begin
                if (q_main.size() == 0) check("main unexpected write", 32'(data), 32'hFFFF);
                else check("main nibble order", 32'(data), 32'(q_main.pop_front()));
            end
            if (m_wr_en) begin
                if (q_msb.size() == 0) check("msb unexpected write", 32'(m_data), 32'hFFFF);
                else check("msb nibble order", 32'(m_data), 32'(q_msb.pop_front()));
            end
            if (n_wr_en) begin
                if (q_small.size() == 0) check("small unexpected write", 32'(n_data), 32'hFFFF);
                else check("small nibble order", 32'(n_data), 32'(q_small.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // v, d, full, xfer | ready, wr_en, data, busy, byte_count, stall_count
        add_vec(1'b1, 8'hA5, 1'b0, 1'b1,  1'b1, 1'b0, 4'h0, 1'b0, 0, 0);
        add_vec(1'b0, 8'hFF, 1'b0, 1'b0,  1'b0, 1'b1, 4'h5, 1'b1, 0, 0);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 4'hA, 1'b1, 0, 0);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b0, 4'h0, 1'b0, 1, 0);
        add_vec(1'b1, 8'h12, 1'b0, 1'b1,  1'b1, 1'b0, 4'h0, 1'b0, 1, 0);
        add_vec(1'b1, 8'h34, 1'b0, 1'b0,  1'b0, 1'b1, 4'h2, 1'b1, 1, 0);
        add_vec(1'b1, 8'h34, 1'b0, 1'b1,  1'b1, 1'b1, 4'h1, 1'b1, 1, 0);
        add_vec(1'b1, 8'h56, 1'b0, 1'b0,  1'b0, 1'b1, 4'h4, 1'b1, 2, 0);
        add_vec(1'b1, 8'h56, 1'b0, 1'b1,  1'b1, 1'b1, 4'h3, 1'b1, 2, 0);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 4'h6, 1'b1, 3, 0);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 4'h5, 1'b1, 3, 0);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b0, 4'h0, 1'b0, 4, 0);
        add_vec(1'b1, 8'hC3, 1'b0, 1'b1,  1'b1, 1'b0, 4'h0, 1'b0, 4, 0);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 4'h3, 1'b1, 4, 0);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b0, 4'hC, 1'b1, 4, 0);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b0, 4'hC, 1'b1, 4, 1);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b0, 4'hC, 1'b1, 4, 2);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 4'hC, 1'b1, 4, 3);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b0, 4'h0, 1'b0, 5, 3);
        add_vec(1'b1, 8'h5A, 1'b1, 1'b1,  1'b1, 1'b0, 4'h0, 1'b0, 5, 3);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 1'b0, 4'hA, 1'b1, 5, 3);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 4'hA, 1'b1, 5, 4);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 4'h5, 1'b1, 5, 4);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b0, 4'h0, 1'b0, 6, 4);
        add_vec(1'b1, 8'h9B, 1'b0, 1'b1,  1'b1, 1'b0, 4'h0, 1'b0, 6, 4);
        add_vec(1'b1, 8'h3C, 1'b0, 1'b0,  1'b0, 1'b1, 4'hB, 1'b1, 6, 4);
        add_vec(1'b1, 8'h3C, 1'b1, 1'b0,  1'b0, 1'b0, 4'h9, 1'b1, 6, 4);
        add_vec(1'b1, 8'h3C, 1'b0, 1'b1,  1'b1, 1'b1, 4'h9, 1'b1, 6, 5);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b0, 1'b1, 4'hC, 1'b1, 7, 5);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b1, 4'h3, 1'b1, 7, 5);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 1'b0, 4'h0, 1'b0, 8, 5);

        // Reset state, with fifo_full high to show it cannot leak into the outputs.
        wr_rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; fifo_full = 1'b1;
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        check("reset s_ready", 32'(ready), 32'd1);
        check("reset fifo_wr_en", 32'(wr_en), 32'd0);
        check("reset fifo_data", 32'(data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset byte_count", 32'(bcnt), 32'd0);
        check("reset stall_count", 32'(scnt), 32'd0);

        // Release just after an edge; row 0 transfers on the first edge after release.
        @(posedge wr_clk); #1;
        wr_rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            s_valid = vecs[i].v; s_data = vecs[i].d; fifo_full = vecs[i].full;
            if (vecs[i].xfer) push_byte(vecs[i].d);
            @(negedge wr_clk);
            check($sformatf("row%0d s_ready", i), 32'(ready), 32'(vecs[i].e_ready));
            check($sformatf("row%0d fifo_wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr));
            check($sformatf("row%0d fifo_data", i), 32'(data), 32'(vecs[i].e_data));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("row%0d byte_count", i), 32'(bcnt), 32'(vecs[i].e_bcnt));
            check($sformatf("row%0d stall_count", i), 32'(scnt), 32'(vecs[i].e_scnt));
            check($sformatf("row%0d small byte_count", i), 32'(n_bcnt), 32'(vecs[i].e_bcnt % 4));
            check($sformatf("row%0d small stall_count", i), 32'(n_scnt),
                  32'((vecs[i].e_scnt > 3) ? 3 : vecs[i].e_scnt));
            @(posedge wr_clk); #1;
        end

        // Reset between the two nibbles of 8'h7E: the high nibble must never be written.
        s_valid = 1'b1; s_data = 8'h7E; fifo_full = 1'b0;
        push_byte(8'h7E);
        @(negedge wr_clk);
        check("mid-reset s_ready", 32'(ready), 32'd1);
        @(posedge wr_clk); #1;
        s_valid = 1'b0; s_data = 8'h00;
        @(negedge wr_clk);
        check("mid-reset first nibble", 32'(data), 32'hE);
        @(posedge wr_clk); #1;
        check("mid-reset second pending", 32'(data), 32'h7);
        wr_rst = 1'b0;
        #1;
        check("async reset fifo_wr_en", 32'(wr_en), 32'd0);
        check("async reset fifo_data", 32'(data), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset s_ready", 32'(ready), 32'd1);
        check("async reset byte_count", 32'(bcnt), 32'd0);
        check("async reset stall_count", 32'(scnt), 32'd0);
        check("async reset small byte_count", 32'(n_bcnt), 32'd0);
        check("main discarded nibbles", 32'(q_main.size()), 32'd1);
        check("msb discarded nibbles", 32'(q_msb.size()), 32'd1);
        q_main.delete(); q_msb.delete(); q_small.delete();
        @(posedge wr_clk);
        @(negedge wr_clk);
        check("held reset fifo_wr_en", 32'(wr_en), 32'd0);
        #2;
        wr_rst = 1'b1;
        s_valid = 1'b1; s_data = 8'h6D;
        push_byte(8'h6D);
        @(posedge wr_clk); #1;
        s_valid = 1'b0; s_data = 8'h00;
        @(negedge wr_clk);
        check("post-reset first nibble", 32'(data), 32'hD);
        check("post-reset fifo_wr_en", 32'(wr_en), 32'd1);
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        check("post-reset second nibble", 32'(data), 32'h6);
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        check("post-reset busy", 32'(busy), 32'd0);
        check("post-reset byte_count", 32'(bcnt), 32'd1);
        repeat (2) @(posedge wr_clk);
        #1;

        check("main queue drained", 32'(q_main.size()), 32'd0);
        check("msb queue drained", 32'(q_msb.size()), 32'd0);
        check("small queue drained", 32'(q_small.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
